alu8_arbiter: RTL

ALU8_ARBITER -- requirements
Module: alu8_arbiter

---
 rtl/alu8_arbiter_pkg.sv | 31 +++
 rtl/alu8.sv | 51 +++++
 rtl/alu8_arbiter.sv | 99 +++++++++
 3 files changed

// File: rtl/alu8_arbiter_pkg.sv
// Shared types and opcode constants for the two-requester ALU arbiter and its ALU.
package alu8_arbiter_pkg;

    localparam int unsigned DATA_W = 8;
    localparam int unsigned OP_W   = 3;
    localparam int unsigned FLAG_W = 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic [OP_W-1:0] OP_ADD  = 3'b000;
    localparam logic [OP_W-1:0] OP_SUB  = 3'b001;
    localparam logic [OP_W-1:0] OP_AND  = 3'b010;
    localparam logic [OP_W-1:0] OP_OR   = 3'b011;
    localparam logic [OP_W-1:0] OP_XOR  = 3'b100;
    localparam logic [OP_W-1:0] OP_SHL  = 3'b101;
    localparam logic [OP_W-1:0] OP_SHR  = 3'b110;
    localparam logic [OP_W-1:0] OP_PASS = 3'b111;

    // Operation captured from the granted requester at accept time.
    typedef struct packed {
        logic [DATA_W-1:0] a;
        logic [DATA_W-1:0] b;
        logic [OP_W-1:0]   op;
        logic              id;
    } req_t;

endpackage

// File: rtl/alu8.sv
// Combinational 8-bit ALU producing the result and {Z,C,V} flags.
module alu8
    import alu8_arbiter_pkg::*;
(
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic [OP_W-1:0]   op,
    output logic [DATA_W-1:0] y_c,
    output logic [FLAG_W-1:0] flags_c
);

    logic [DATA_W:0] wide;
    logic            carry;
    logic            ovf;

    // C is carry-out for add, borrow for sub, the shifted-out bit for shifts.
    always_comb begin
        wide  = '0;
        y_c   = '0;
        carry = 1'b0;
        ovf   = 1'b0;
        case (op)
            OP_ADD: begin
                wide  = {1'b0, a} + {1'b0, b};
                y_c   = wide[DATA_W-1:0];
                carry = wide[DATA_W];
                ovf   = (a[DATA_W-1] == b[DATA_W-1]) && (y_c[DATA_W-1] != a[DATA_W-1]);
            end
            OP_SUB: begin
                wide  = {1'b0, a} - {1'b0, b};
                y_c   = wide[DATA_W-1:0];
                carry = wide[DATA_W];
                ovf   = (a[DATA_W-1] != b[DATA_W-1]) && (y_c[DATA_W-1] != a[DATA_W-1]);
            end
            OP_AND: y_c = a & b;
            OP_OR:  y_c = a | b;
            OP_XOR: y_c = a ^ b;
            OP_SHL: begin
                y_c   = {a[DATA_W-2:0], 1'b0};
                carry = a[DATA_W-1];
            end
            OP_SHR: begin
                y_c   = {1'b0, a[DATA_W-1:1]};
                carry = a[0];
            end
            default: y_c = a;
        endcase
        flags_c = {(y_c == '0), carry, ovf};
    end

endmodule

// File: rtl/alu8_arbiter.sv
// Round-robin arbiter feeding two requesters into one shared ALU, one operation at a time.
module alu8_arbiter
    import alu8_arbiter_pkg::*;
#(
    parameter int unsigned RR_INIT = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [DATA_W-1:0] req0_a,
    input  logic [DATA_W-1:0] req0_b,
    input  logic [OP_W-1:0]   req0_op,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [DATA_W-1:0] req1_a,
    input  logic [DATA_W-1:0] req1_b,
    input  logic [OP_W-1:0]   req1_op,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic              rsp_id,
    output logic [DATA_W-1:0] rsp_y,
    output logic [FLAG_W-1:0] rsp_flags,
    output logic              busy,
    output logic [7:0]        op_count
);

    state_t            state;
    req_t              held;
    logic              last;
    logic              grant;
    logic              accept;
    logic [DATA_W-1:0] alu_y;
    logic [FLAG_W-1:0] alu_flags;

    // On a tie the requester not served last wins; otherwise the lone valid one.
    always_comb begin
        grant      = (req0_valid && req1_valid) ? ~last : req1_valid;
        req0_ready = rst_n && (state == IDLE) && req0_valid && !grant;
        req1_ready = rst_n && (state == IDLE) && req1_valid && grant;
        accept     = req0_ready || req1_ready;
    end

    alu8 u_alu (
        .a       (held.a),
        .b       (held.b),
        .op      (held.op),
        .y_c     (alu_y),
        .flags_c (alu_flags)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            held      <= '0;
            last      <= ~1'(RR_INIT);
            rsp_valid <= 1'b0;
            rsp_id    <= 1'b0;
            rsp_y     <= '0;
            rsp_flags <= '0;
            busy      <= 1'b0;
            op_count  <= 8'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        held.a  <= grant ? req1_a  : req0_a;
                        held.b  <= grant ? req1_b  : req0_b;
                        held.op <= grant ? req1_op : req0_op;
                        held.id <= grant;
                        state   <= EXEC;
                        busy    <= 1'b1;
                    end
                end
                EXEC: begin
                    rsp_y     <= alu_y;
                    rsp_flags <= alu_flags;
                    rsp_id    <= held.id;
                    rsp_valid <= 1'b1;
                    state     <= RESP;
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        last      <= rsp_id;
                        op_count  <= op_count + 8'd1;
                        state     <= IDLE;
                        busy      <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
